// File: rtl/lvds_frame_aligner.sv
// Word-alignment controller for LVDS ADC receivers. It pulses bitslip until the
// deserialised frame word matches FRAME_PATTERN, then holds lock and watches for loss of lock.
module lvds_frame_aligner #(
    parameter int                N_CH          = 4,
    parameter int                WORD_W        = 8,
    parameter logic [WORD_W-1:0] FRAME_PATTERN = 8'hF0,
    parameter int                HOLDOFF       = 16,
    parameter int                LOCK_CNT      = 64,
    parameter int                LOSS_CNT      = 4,
    parameter int                MAX_SLIPS     = 16
) (
    input  logic                     sample_clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [WORD_W-1:0]        frame_word,
    input  logic [N_CH*WORD_W-1:0]   data_in,
    output logic                     bitslip,
    output logic [N_CH*WORD_W-1:0]   data_out,
    output logic                     data_valid,
    output logic                     locked,
    output logic                     align_err,
    output logic [7:0]               slip_count,
    output logic [15:0]              relock_count
);

    localparam int HOLD_W  = $clog2(HOLDOFF + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [MATCH_W-1:0] LOCK_TGT  = MATCH_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  LOSS_TGT  = MISS_W'(LOSS_CNT);
    localparam logic [7:0]         SLIP_MAX  = 8'(MAX_SLIPS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD   = 3'd1,
        S_CHECK  = 3'd2,
        S_SLIP   = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic [MATCH_W-1:0]       match_q, match_d;
    logic [MISS_W-1:0]        miss_q, miss_d;
    logic [7:0]               slip_q, slip_d;
    logic [15:0]              relock_q, relock_d;
    logic                     bitslip_q, locked_q, valid_q, align_err_q;
    logic [N_CH*WORD_W-1:0]   data_q;

    logic                     frame_match;
    logic [MATCH_W-1:0]       match_inc;
    logic [MISS_W-1:0]        miss_inc;
    logic [7:0]               slip_sat;
    logic [15:0]              relock_sat;

    assign frame_match = (frame_word == FRAME_PATTERN);
    assign match_inc   = match_q + 1'b1;
    assign miss_inc    = miss_q + 1'b1;
    assign slip_sat    = (slip_q == 8'hFF) ? slip_q : slip_q + 8'd1;
    assign relock_sat  = (relock_q == 16'hFFFF) ? relock_q : relock_q + 16'd1;

    // Next-state and counter logic; a low enable overrides every other transition.
    always_comb begin
        state_d  = state_q;
        hold_d   = {HOLD_W{1'b0}};
        match_d  = {MATCH_W{1'b0}};
        miss_d   = {MISS_W{1'b0}};
        slip_d   = slip_q;
        relock_d = relock_q;
        if (!enable) begin
            state_d = S_IDLE;
            slip_d  = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    slip_d  = 8'd0;
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_CHECK;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (frame_match) begin
                        if (match_inc == LOCK_TGT) begin
                            state_d = S_LOCKED;
                        end else begin
                            match_d = match_inc;
                        end
                    end else if (slip_q < SLIP_MAX) begin
                        state_d = S_SLIP;
                        slip_d  = slip_sat;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
                S_SLIP: begin
                    state_d = S_HOLD;
                end
                S_LOCKED: begin
                    if (frame_match) begin
                        miss_d = {MISS_W{1'b0}};
                    end else if (miss_inc == LOSS_TGT) begin
                        state_d  = S_HOLD;
                        relock_d = relock_sat;
                        slip_d   = 8'd0;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs; flags are decoded from the next state
    // so they are valid from the first cycle spent in that state.
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= {HOLD_W{1'b0}};
            match_q     <= {MATCH_W{1'b0}};
            miss_q      <= {MISS_W{1'b0}};
            slip_q      <= 8'd0;
            relock_q    <= 16'd0;
            bitslip_q   <= 1'b0;
            locked_q    <= 1'b0;
            valid_q     <= 1'b0;
            align_err_q <= 1'b0;
            data_q      <= {(N_CH*WORD_W){1'b0}};
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            slip_q      <= slip_d;
            relock_q    <= relock_d;
            bitslip_q   <= (state_d == S_SLIP);
            locked_q    <= (state_d == S_LOCKED);
            valid_q     <= (state_d == S_LOCKED);
            align_err_q <= (state_d == S_FAIL);
            data_q      <= data_in;
        end
    end

    assign bitslip      = bitslip_q;
    assign data_out     = data_q;
    assign data_valid   = valid_q;
    assign locked       = locked_q;
    assign align_err    = align_err_q;
    assign slip_count   = slip_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_lvds_frame_aligner.sv
// Bench for lvds_frame_aligner: a frame-lane model that rotates on each bitslip,
// a data_out scoreboard fed by the data driver, and directed alignment scenarios.
module tb_lvds_frame_aligner;

    localparam int N_CH = 4;
    localparam int WORD_W = 8;
    localparam int HOLDOFF = 4;
    localparam int LOCK_CNT = 8;
    localparam int LOSS_CNT = 4;
    localparam int MAX_SLIPS = 16;
    localparam logic [7:0] PAT = 8'hF0;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [7:0]   frame_word;
    logic [31:0]  data_in;
    logic         bitslip;
    logic [31:0]  data_out;
    logic         data_valid;
    logic         locked;
    logic         align_err;
    logic [7:0]   slip_count;
    logic [15:0]  relock_count;

    int           checks = 0;
    int           failures = 0;
    int           pulse_cnt = 0;
    int           slip_applied = 0;
    int           rot_base = 0;
    logic         force_en = 1'b0;
    logic [7:0]   force_val = 8'h00;
    logic [31:0]  exp_q[$];

    lvds_frame_aligner #(
        .N_CH(N_CH), .WORD_W(WORD_W), .FRAME_PATTERN(PAT), .HOLDOFF(HOLDOFF),
        .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .MAX_SLIPS(MAX_SLIPS)
    ) dut (
        .sample_clk(clk), .reset(reset), .enable(enable), .frame_word(frame_word),
        .data_in(data_in), .bitslip(bitslip), .data_out(data_out),
        .data_valid(data_valid), .locked(locked), .align_err(align_err),
        .slip_count(slip_count), .relock_count(relock_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < (n & 7); i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    assign frame_word = force_en ? force_val : rotl(PAT, rot_base + slip_applied);

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // which: 0 = locked, 1 = bitslip, 2 = align_err; counts as a failed check on timeout
    task automatic wait_sig(input int which, input int budget, input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            case (which)
                0: seen = locked;
                1: seen = bitslip;
                2: seen = align_err;
                default: seen = 1'b0;
            endcase
        end
        chk(nm, seen, 1);
    endtask

    task automatic monitor();
        logic [31:0] e;
        logic        prev_bs;
        logic [1:0]  pipe;
        int          cyc;
        int          last_pulse;
        prev_bs = 1'b0;
        pipe = 2'b00;
        cyc = 0;
        last_pulse = -1000;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data_out", data_out, e);
            end
            chk("valid_eq_locked", data_valid, locked);
            if (bitslip) begin
                chk("bitslip_width", prev_bs, 0);
                chk_range("bitslip_gap", cyc - last_pulse, HOLDOFF + 1, 1000000);
                last_pulse = cyc;
                pulse_cnt++;
            end
            // the ISERDES model applies each slip two cycles after the pulse
            if (pipe[1]) slip_applied++;
            pipe = {pipe[0], bitslip};
            prev_bs = bitslip;
        end
    endtask

    task automatic data_driver();
        logic [7:0] base;
        base = 8'd0;
        forever begin
            @(posedge clk); #2;
            base = base + 8'd1;
            data_in = {base + 8'd3, base + 8'd2, base + 8'd1, base};
            @(negedge clk); #1;
            exp_q.push_back(reset ? 32'd0 : data_in);
        end
    endtask

    initial begin
        int p0;
        int n;
        logic hold_ok;
        reset = 1'b1;
        enable = 1'b0;
        data_in = 32'd0;
        fork
            monitor();
            data_driver();
        join_none

        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        chk("rst_bitslip", bitslip, 0);
        chk("rst_locked", locked, 0);
        chk("rst_align_err", align_err, 0);
        chk("rst_slip_count", slip_count, 0);
        chk("rst_relock_count", relock_count, 0);
        chk("rst_data_out", data_out, 0);
        @(negedge clk); reset = 1'b0;

        // aligned from start: 1 IDLE + 4 HOLD + 8 CHECK edges
        @(negedge clk); enable = 1'b1; p0 = pulse_cnt; n = 0;
        for (int i = 0; i < 40 && !locked; i++) begin
            @(posedge clk); #1; n++;
        end
        chk_range("s1_lock_latency", n, 12, 14);
        chk("s1_locked", locked, 1);
        chk("s1_pulses", pulse_cnt - p0, 0);
        chk("s1_slip_count", slip_count, 0);

        // misaligned by 3: five slips bring the pattern round
        @(negedge clk); enable = 1'b0;
        repeat (3) @(negedge clk);
        rot_base = 3 - slip_applied;
        enable = 1'b1; p0 = pulse_cnt;
        wait_sig(0, 300, "s2_lock");
        chk("s2_pulses", pulse_cnt - p0, 5);
        chk("s2_slip_count", slip_count, 5);

        // never aligns: 16 slips then FAIL
        @(negedge clk); enable = 1'b0; force_en = 1'b1; force_val = 8'h00;
        repeat (3) @(negedge clk);
        enable = 1'b1; p0 = pulse_cnt;
        wait_sig(2, 400, "s3_align_err");
        chk("s3_pulses", pulse_cnt - p0, 16);
        chk("s3_slip_count", slip_count, 16);
        repeat (20) @(posedge clk); #1;
        chk("s3_no_more_pulses", pulse_cnt - p0, 16);
        chk("s3_align_err_held", align_err, 1);
        @(negedge clk); enable = 1'b0;
        @(posedge clk); #1;
        chk("s3_align_err_clr", align_err, 0);
        chk("s3_slip_clr", slip_count, 0);
        @(negedge clk); enable = 1'b1;
        @(posedge clk); #1;
        chk("s3_restart_slip", slip_count, 0);
        wait_sig(1, 40, "s3_restart_pulse");
        chk("s3_restart_slip1", slip_count, 1);

        // glitch versus loss of lock
        @(negedge clk); enable = 1'b0; force_en = 1'b0;
        repeat (3) @(negedge clk);
        rot_base = -slip_applied;
        enable = 1'b1;
        wait_sig(0, 100, "s4_lock");
        @(negedge clk); force_en = 1'b1; force_val = 8'h0F;
        repeat (3) @(negedge clk);
        force_en = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            hold_ok = hold_ok & locked;
        end
        chk("s4_glitch_locked_held", hold_ok, 1);
        chk("s4_glitch_relock_cnt", relock_count, 0);
        @(negedge clk); force_en = 1'b1;
        repeat (4) @(negedge clk);
        force_en = 1'b0;
        @(posedge clk); #1;
        chk("s4_loss_locked", locked, 0);
        chk("s4_loss_valid", data_valid, 0);
        chk("s4_relock_cnt", relock_count, 1);
        wait_sig(0, 60, "s4_relock");
        chk("s4_relock_slips", slip_count, 0);

        // enable drop while LOCKED keeps relock_count
        @(negedge clk); enable = 1'b0;
        @(posedge clk); #1;
        chk("s6_en_locked", locked, 0);
        chk("s6_en_valid", data_valid, 0);
        chk("s6_en_bitslip", bitslip, 0);
        chk("s6_en_relock_kept", relock_count, 1);

        // reset while a bitslip pulse is out; that pulse still reaches the model
        repeat (3) @(negedge clk);
        rot_base = 3 - slip_applied;
        enable = 1'b1;
        wait_sig(1, 40, "s6_pulse");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("s6_rst_bitslip", bitslip, 0);
        chk("s6_rst_locked", locked, 0);
        chk("s6_rst_valid", data_valid, 0);
        chk("s6_rst_align_err", align_err, 0);
        chk("s6_rst_slip", slip_count, 0);
        chk("s6_rst_relock", relock_count, 0);
        @(negedge clk); reset = 1'b0;
        wait_sig(0, 300, "s6_relock");
        chk("s6_relock_slips", slip_count, 4);

        repeat (4) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lvds_frame_aligner.md
Name: lvds_frame_aligner

Overview:
Automatic word-alignment controller for multi-lane LVDS ADC receivers (LTC-style frame clock plus N data lanes). It sits after the ISERDES deserialisers in the sample_clk domain. It watches the deserialised frame-clock word and issues single-cycle bitslip pulses until that word matches the frame pattern. It then declares lock, forwards aligned data with a valid flag, monitors for loss of lock and re-aligns automatically. It replaces hand-driven bitslip pulsing with a parametrised, self-checking state machine.

Parameters:
N_CH, 4, number of data lanes forwarded alongside the frame lane
WORD_W, 8, deserialisation factor (bits per word per lane)
FRAME_PATTERN, 8'hF0, expected frame word when aligned (WORD_W bits)
HOLDOFF, 16, sample_clk cycles to wait after a bitslip or (re)start before comparing (>=1)
LOCK_CNT, 64, consecutive matching frame words required to declare lock (>=1)
LOSS_CNT, 4, consecutive mismatches in LOCKED that declare loss of lock (>=1)
MAX_SLIPS, 16, bitslip attempts allowed per alignment run before FAIL (typically 2*WORD_W)

Ports:
sample_clk  in  1  word clock from the ISERDES divided clock; all logic is on its rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  run alignment; low forces IDLE
frame_word  in  WORD_W  deserialised frame-clock lane
data_in  in  N_CH*WORD_W  deserialised data lanes, lane 0 in the LSBs
bitslip  out  1  one-cycle pulse to all ISERDES BITSLIP inputs
data_out  out  N_CH*WORD_W  data_in registered once
data_valid  out  1  high while locked
locked  out  1  alignment achieved and held
align_err  out  1  MAX_SLIPS exhausted without lock
slip_count  out  8  bitslips issued in the current run (saturating at 255)
relock_count  out  16  loss-of-lock events since reset (saturating at 65535)

Behaviour:
- Reset values: all outputs 0, data_out 0, FSM in IDLE, all internal counters 0.
- States: IDLE, HOLD, CHECK, SLIP, LOCKED, FAIL.
- IDLE: if enable=1, go to HOLD. On entry to IDLE, clear slip_count.
- HOLD: count HOLDOFF cycles. When the count completes, go to CHECK with the match counter at 0.
- CHECK: compare frame_word with FRAME_PATTERN every cycle.
  - Match: increment the match counter. When it reaches LOCK_CNT, go to LOCKED.
  - Mismatch with slip_count < MAX_SLIPS: go to SLIP.
  - Mismatch with slip_count >= MAX_SLIPS: go to FAIL.
- SLIP: bitslip=1 for exactly this one cycle, slip_count+1, then HOLD. bitslip is never high in two consecutive cycles. Back-to-back pulses are separated by at least HOLDOFF+1 cycles.
- LOCKED: locked=1 and data_valid=1, both registered and asserted from the first cycle in LOCKED.
  - A mismatch increments the miss counter; any match clears it.
  - When the miss counter reaches LOSS_CNT: drop locked and data_valid in the next cycle, increment relock_count, clear slip_count, go to HOLD.
  - A single isolated mismatch does not drop lock.
- FAIL: align_err=1, no bitslip. Stay in FAIL until enable=0, then go to IDLE; align_err clears in IDLE.
- enable=0 in any state: next state is IDLE. locked, data_valid and bitslip go low one cycle later; this has priority over every other transition.
- reset mid-operation: returns to the reset values on the next edge, including relock_count. Any bitslip pulse in flight is truncated to that cycle.
- data_out: data_in delayed by exactly 1 cycle in all states. Consumers gate it with data_valid.
- Counter widths: $clog2(max+1) internally; slip_count and relock_count saturate and never wrap.

Test Plan:
- Scenario 1, aligned from start. Stimulus: WORD_W=8, FRAME_PATTERN=8'hF0, HOLDOFF=4, LOCK_CNT=8, model frame_word=8'hF0 constant, enable=1 after reset. Required: zero bitslip pulses; locked rises 1+4+8 cycles after enable (±1, documented by the bench); slip_count=0.
- Scenario 2, misaligned start. Stimulus: model frame word rotated left 3; each bitslip rotates it by 1 after a 2-cycle pipeline. Required: exactly 5 pulses (8-3), each 1 cycle wide and spaced ≥5 cycles apart; then lock; slip_count=5.
- Scenario 3, never aligns. Stimulus: frame_word=8'h00 constant, MAX_SLIPS=16. Required: 16 pulses, then align_err=1 and no further pulses. Deassert enable: align_err=0 next cycle. Reassert enable: restart with slip_count=0.
- Scenario 4, glitch vs loss. Stimulus: locked with LOSS_CNT=4; inject 3 mismatches then a match. Required: locked held. Then inject 4 mismatches. Required: locked=0, relock_count=1, realign, relock.
- Scenario 5, data path. Stimulus: data_in counting ramp on each lane. Required: data_out equals the previous cycle's data_in; data_valid==locked every cycle.
- Scenario 6, reset and enable override. Stimulus: assert reset during SLIP, and separately drop enable while LOCKED. Required: bitslip low next cycle, all outputs at reset or IDLE values, relock_count cleared only by reset.
